// File: rtl/multicycle_sequencer.sv
// Control sequencer for a multicycle CPU: FETCH/DECODE/EXEC/MEM/WB(/FAULT) walking one instruction at a time.
// Latency: R-type 4, LW 5, SW 4, BEQ/BNE/J 3 cycles when memory answers on the first request.
// Backpressure: FETCH and MEM hold with stable outputs until mem_rdy; optional MEM_TIMEOUT_EN traps a stuck memory in FAULT.
module multicycle_sequencer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       mem_rdy,
  input  logic       zero,
  output logic       ir_load,
  output logic       pc_load,
  output logic [1:0] pc_src,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       instr_done,
  output logic [2:0] state,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  localparam logic [3:0] OP_LW  = 4'b0000;
  localparam logic [3:0] OP_SW  = 4'b0001;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_BNE = 4'b1100;
  localparam logic [3:0] OP_J   = 4'b1101;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [1:0] ALU_R   = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;

  // Opcode class flags, always derived from the latched opcode.
  logic is_lw, is_sw, is_beq, is_bne, is_j, is_rtype;

  // Timeout trigger: high in the wait cycle that exhausts the budget.
  logic timeout_hit;

  // Ungated control outputs; reset gating is applied afterwards.
  logic       ir_load_c, pc_load_c, mem_req_c, mem_we_c, iord_c;
  logic       reg_write_c, mem_to_reg_c, reg_dst_c, instr_done_c, fault_c;
  logic [1:0] pc_src_c, alu_op_c;

  // Decode the latched opcode into instruction classes.
  always_comb begin
    is_lw    = (op_q == OP_LW);
    is_sw    = (op_q == OP_SW);
    is_beq   = (op_q == OP_BEQ);
    is_bne   = (op_q == OP_BNE);
    is_j     = (op_q == OP_J);
    is_rtype = !(is_lw || is_sw || is_beq || is_bne || is_j);
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          waiting;

  // Count consecutive unanswered memory cycles; any answer or state change restarts it.
  always_comb begin
    waiting     = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_rdy;
    wait_cnt_d  = '0;
    timeout_hit = 1'b0;
    if (waiting) begin
      wait_cnt_d  = wait_cnt_q + CW'(1);
      timeout_hit = ((int'(wait_cnt_q) + 1) >= TIMEOUT_CYCLES);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;

  // Without the timeout option memory waits forever and FAULT is never entered.
  always_comb begin
    timeout_hit = 1'b0;
  end

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Next-state and raw control outputs; everything not asserted below stays 0.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    ir_load_c    = 1'b0;
    pc_load_c    = 1'b0;
    pc_src_c     = PC_INC;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    iord_c       = 1'b0;
    alu_op_c     = ALU_R;
    reg_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_dst_c    = 1'b0;
    instr_done_c = 1'b0;
    fault_c      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b0;
        if (mem_rdy) begin
          ir_load_c = 1'b1;
          pc_load_c = 1'b1;
          pc_src_c  = PC_INC;
          state_d   = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end

      S_DECODE: begin
        // The external IR is only trusted here; later states work from op_q.
        op_d    = opcode;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        if (is_lw || is_sw) begin
          alu_op_c = ALU_ADD;
          state_d  = S_MEM;
        end else if (is_beq || is_bne) begin
          alu_op_c     = ALU_SUB;
          pc_src_c     = PC_BR;
          pc_load_c    = is_beq ? zero : !zero;
          instr_done_c = 1'b1;
          state_d      = S_FETCH;
        end else if (is_j) begin
          alu_op_c     = ALU_R;
          pc_src_c     = PC_JMP;
          pc_load_c    = 1'b1;
          instr_done_c = 1'b1;
          state_d      = S_FETCH;
        end else begin
          alu_op_c = ALU_R;
          state_d  = S_WB;
        end
      end

      S_MEM: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        mem_we_c  = is_sw;
        if (mem_rdy) begin
          if (is_sw) begin
            instr_done_c = 1'b1;
            state_d      = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end

      S_WB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        mem_to_reg_c = is_lw;
        reg_dst_c    = is_rtype;
        state_d      = S_FETCH;
      end

      S_FAULT: begin
`ifdef MEM_TIMEOUT_EN
        // Sticky until reset: a hung memory must not be silently retried.
        fault_c = 1'b1;
        state_d = S_FAULT;
`else
        state_d = S_FETCH;
`endif
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State and latched opcode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Force every output low while reset is held, so a reset mid-access drops mem_req at once.
  always_comb begin
    ir_load    = ir_load_c & rst_n;
    pc_load    = pc_load_c & rst_n;
    pc_src     = pc_src_c & {2{rst_n}};
    mem_req    = mem_req_c & rst_n;
    mem_we     = mem_we_c & rst_n;
    iord       = iord_c & rst_n;
    alu_op     = alu_op_c & {2{rst_n}};
    reg_write  = reg_write_c & rst_n;
    mem_to_reg = mem_to_reg_c & rst_n;
    reg_dst    = reg_dst_c & rst_n;
    instr_done = instr_done_c & rst_n;
    state      = state_q & {3{rst_n}};
    fault      = fault_c & rst_n;
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-cycle expected outputs are queued with their stimulus, then replayed and compared.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Covers every opcode class, memory stalls, opcode changes after DECODE, and reset in and out of an access.
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       mem_rdy;
  logic       zero;
  logic       ir_load, pc_load, mem_req, mem_we, iord;
  logic [1:0] pc_src, alu_op;
  logic       reg_write, mem_to_reg, reg_dst, instr_done, fault;
  logic [2:0] state;

  multicycle_sequencer #(.TIMEOUT_CYCLES(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_rdy    (mem_rdy),
    .zero       (zero),
    .ir_load    (ir_load),
    .pc_load    (pc_load),
    .pc_src     (pc_src),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .instr_done (instr_done),
    .state      (state),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_load;
    logic       pc_load;
    logic [1:0] pc_src;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       instr_done;
    logic       fault;
  } out_t;

  typedef struct packed {
    logic [3:0] opc;
    logic       rdy;
    logic       zr;
    out_t       want;
  } step_t;

  step_t sq[$];
  string tq[$];
  int    vectors     = 0;
  int    miscompares = 0;

  function automatic out_t mk(input logic [2:0] st, input logic irl, input logic pcl,
                              input logic [1:0] pcs, input logic mrq, input logic mwe,
                              input logic iod, input logic [1:0] alu, input logic rw,
                              input logic m2r, input logic rd, input logic dn);
    out_t o;
    o.st = st; o.ir_load = irl; o.pc_load = pcl; o.pc_src = pcs;
    o.mem_req = mrq; o.mem_we = mwe; o.iord = iod; o.alu_op = alu;
    o.reg_write = rw; o.mem_to_reg = m2r; o.reg_dst = rd; o.instr_done = dn;
    o.fault = 1'b0;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.st = state; o.ir_load = ir_load; o.pc_load = pc_load; o.pc_src = pc_src;
    o.mem_req = mem_req; o.mem_we = mem_we; o.iord = iord; o.alu_op = alu_op;
    o.reg_write = reg_write; o.mem_to_reg = mem_to_reg; o.reg_dst = reg_dst;
    o.instr_done = instr_done; o.fault = fault;
    return o;
  endfunction

  task automatic push(input logic [3:0] o, input logic r, input logic z, input out_t w, input string t);
    step_t s;
    s.opc = o; s.rdy = r; s.zr = z; s.want = w;
    sq.push_back(s);
    tq.push_back(t);
  endtask

  task automatic check(input out_t want, input string tag);
    out_t obs;
    obs = sample();
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Caller is at a falling edge; each step drives, checks, then moves to the next falling edge.
  task automatic drain();
    step_t s;
    string t;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      t = tq.pop_front();
      opcode  = s.opc;
      mem_rdy = s.rdy;
      zero    = s.zr;
      #1;
      check(s.want, t);
      @(negedge clk);
    end
  endtask

  // Queue one whole instruction. 'alt' is driven from EXEC onward and must be ignored.
  task automatic push_instr(input string nm, input logic [3:0] op, input logic [3:0] alt,
                            input logic z, input int fw, input int mw);
    logic sw;
    sw = (op == 4'b0001);
    for (int i = 0; i < fw; i++)
      push(op, 1'b0, z, mk(3'd0, 0, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0), {nm, "_fetch_wait"});
    push(op, 1'b1, z, mk(3'd0, 1, 1, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0), {nm, "_fetch"});
    push(op, 1'b1, z, mk(3'd1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0), {nm, "_decode"});
    case (op)
      4'b0000, 4'b0001: begin
        push(alt, 1'b1, z, mk(3'd2, 0, 0, 2'b00, 0, 0, 0, 2'b10, 0, 0, 0, 0), {nm, "_exec"});
        for (int i = 0; i < mw; i++)
          push(alt, 1'b0, z, mk(3'd3, 0, 0, 2'b00, 1, sw, 1, 2'b00, 0, 0, 0, 0), {nm, "_mem_wait"});
        push(alt, 1'b1, z, mk(3'd3, 0, 0, 2'b00, 1, sw, 1, 2'b00, 0, 0, 0, sw), {nm, "_mem"});
        if (!sw)
          push(alt, 1'b1, z, mk(3'd4, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 1), {nm, "_wb"});
      end
      4'b1011: push(alt, 1'b1, z, mk(3'd2, 0, z, 2'b01, 0, 0, 0, 2'b01, 0, 0, 0, 1), {nm, "_exec"});
      4'b1100: push(alt, 1'b1, z, mk(3'd2, 0, !z, 2'b01, 0, 0, 0, 2'b01, 0, 0, 0, 1), {nm, "_exec"});
      4'b1101: push(alt, 1'b1, z, mk(3'd2, 0, 1, 2'b10, 0, 0, 0, 2'b00, 0, 0, 0, 1), {nm, "_exec"});
      default: begin
        push(alt, 1'b1, z, mk(3'd2, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0), {nm, "_exec"});
        push(alt, 1'b1, z, mk(3'd4, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 1, 1), {nm, "_wb"});
      end
    endcase
  endtask

  out_t zeros;
  out_t fetch_idle;
  out_t faulted;

  initial begin
    zeros      = mk(3'd0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    fetch_idle = mk(3'd0, 0, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    faulted    = mk(3'd5, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    faulted.fault = 1'b1;

    // Reset held with memory ready: every output must still be 0.
    rst_n = 1'b0; opcode = 4'b0010; mem_rdy = 1'b1; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1 check(zeros, "reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;

    // Instruction mix; first step is the cycle right after reset release.
    push_instr("rtype_0010", 4'b0010, 4'b0000, 1'b0, 0, 0);
    push_instr("rtype_1111", 4'b1111, 4'b0001, 1'b1, 1, 0);
    push_instr("lw_stall3",  4'b0000, 4'b0010, 1'b0, 0, 3);
    push_instr("sw_fwait2",  4'b0001, 4'b0000, 1'b0, 2, 0);
    push_instr("sw_stall1",  4'b0001, 4'b1101, 1'b1, 0, 1);
    push_instr("beq_z1",     4'b1011, 4'b1100, 1'b1, 0, 0);
    push_instr("beq_z0",     4'b1011, 4'b1100, 1'b0, 0, 0);
    push_instr("bne_z1",     4'b1100, 4'b1011, 1'b1, 0, 0);
    push_instr("bne_z0",     4'b1100, 4'b1011, 1'b0, 0, 0);
    push_instr("j_alt_sw",   4'b1101, 4'b0001, 1'b0, 0, 0);
    push_instr("rtype_1110", 4'b1110, 4'b0000, 1'b0, 0, 0);
    push_instr("rtype_1010", 4'b1010, 4'b1011, 1'b1, 0, 0);
    drain();

    // Reset asserted while a store sits in MEM.
    push(4'b0001, 1'b1, 1'b0, mk(3'd0, 1, 1, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0), "swrst_fetch");
    push(4'b0001, 1'b1, 1'b0, mk(3'd1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0), "swrst_decode");
    push(4'b0001, 1'b1, 1'b0, mk(3'd2, 0, 0, 2'b00, 0, 0, 0, 2'b10, 0, 0, 0, 0), "swrst_exec");
    push(4'b0001, 1'b0, 1'b0, mk(3'd3, 0, 0, 2'b00, 1, 1, 1, 2'b00, 0, 0, 0, 0), "swrst_mem_wait");
    drain();
    mem_rdy = 1'b0;
    #1 check(mk(3'd3, 0, 0, 2'b00, 1, 1, 1, 2'b00, 0, 0, 0, 0), "swrst_mem_held");
    rst_n = 1'b0;
    #1 check(zeros, "swrst_mid_access");
    @(negedge clk);
    #1 check(zeros, "swrst_held");
    rst_n = 1'b1;
    #1 check(fetch_idle, "swrst_release_fetch");
    @(negedge clk);
    push_instr("post_rst_rtype", 4'b0011, 4'b0000, 1'b0, 0, 0);
    push_instr("post_rst_lw",    4'b0000, 4'b0001, 1'b0, 0, 0);
    drain();

`ifdef MEM_TIMEOUT_EN
    // Memory never answers in FETCH: 15 wait cycles, then FAULT that ignores mem_rdy.
    for (int i = 0; i < 15; i++) push(4'b0010, 1'b0, 1'b0, fetch_idle, "tmo_fetch_wait");
    for (int i = 0; i < 3; i++)  push(4'b0010, 1'b1, 1'b0, faulted, "tmo_fault_sticky");
    drain();
    rst_n = 1'b0;
    #1 check(zeros, "tmo_reset_clears");
    @(negedge clk);
    rst_n = 1'b1;
    push_instr("tmo_recover", 4'b0100, 4'b0000, 1'b0, 3, 0);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
